byte_packer: RTL

- Receive-side counterpart of the 8-bit serializer.
- Accepts a stream of 8-bit bytes, most significant byte first, and reassembles them into 8-, 16- or 32-bit words according to dataS.
- Sits at the receiving end of the 8-bit link; feeds downstream logic that consumes wide words.
- Word boundaries come from an internal byte counter, optionally realigned by a sync marker.

---
 rtl/byte_packer.sv | 87 ++++++++
 1 files changed

// File: rtl/byte_packer.sv
// byte_packer: reassembles an MSB-first byte stream into 8/16/32-bit words
module byte_packer #(
  parameter int PwrC = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enb,
  input  logic [7:0]  dataIn,
  input  logic        validIn,
  input  logic        sync,
  input  logic [1:0]  dataS,
  output logic [7:0]  dataOut8,
  output logic [15:0] dataOut16,
  output logic [31:0] dataOut32,
  output logic        validOut,
  output logic        alignErr
);
  localparam logic [1:0] M8  = 2'b00;
  localparam logic [1:0] M16 = 2'b01;
  localparam logic [1:0] M32 = 2'b10;
  logic [1:0]  prev_q, prev_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] hold_q, hold_d;
  logic [7:0]  out8_q, out8_d;
  logic [15:0] out16_q, out16_d;
  logic [31:0] out32_q, out32_d;
  logic        vld_q, vld_d;
  logic        err_q, err_d;
  logic [1:0]  mode, cur, pos, idx;
  logic        chg, restart, acc, last;
  // decode mode, byte position and word completion, then compute next state
  always_comb begin
    mode    = (dataS == 2'b11) ? M8 : dataS;
    chg     = mode != prev_q;
    cur     = chg ? 2'd0 : (mode == M16) ? {1'b0, ~cnt_q[1] & cnt_q[0]} : (mode == M32) ? cnt_q : 2'd0;
    restart = sync && mode != M8;
    pos     = restart ? 2'd0 : cur;
    idx     = 2'd3 - pos;
    acc     = enb & validIn;
    last    = (mode == M8) || (mode == M16 && pos == 2'd1) || (mode == M32 && pos == 2'd3);
    prev_d  = enb ? mode : prev_q;
    cnt_d   = enb ? cur : cnt_q;
    hold_d  = hold_q;
    out8_d  = out8_q;
    out16_d = out16_q;
    out32_d = out32_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    if (acc) begin
      err_d = restart && !chg && cur != 2'd0;
      vld_d = last;
      cnt_d = last ? 2'd0 : pos + 2'd1;
      if (!last && mode == M16) hold_d[15:8] = dataIn;
      if (!last && mode == M32) hold_d[{idx, 3'b000} +: 8] = dataIn;
      if (mode == M8) out8_d = dataIn;
      if (last && mode == M16) out16_d = {hold_q[15:8], dataIn};
      if (last && mode == M32) out32_d = {hold_q[31:8], dataIn};
    end
  end
  // state registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q  <= M8;
      cnt_q   <= 2'(PwrC);
      hold_q  <= '0;
      out8_q  <= '0;
      out16_q <= '0;
      out32_q <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      out8_q  <= out8_d;
      out16_q <= out16_d;
      out32_q <= out32_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end
  assign dataOut8  = out8_q;
  assign dataOut16 = out16_q;
  assign dataOut32 = out32_q;
  assign validOut  = vld_q;
  assign alignErr  = err_q;
endmodule
